// File: rtl/npu_mem_arbiter_if.sv
// rtl/npu_mem_arbiter_if.sv - CPU/NPU request ports and SRAM port of the data-memory arbiter
interface npu_mem_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic          cpu_rd;
   logic          cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wd;
   logic          cpu_haz;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          npu_req;
   logic          npu_we;
   logic [AW-1:0] npu_addr;
   logic [DW-1:0] npu_wd;
   logic [7:0]    npu_burst_len;
   logic          npu_ack;
   logic          npu_rvalid;
   logic [DW-1:0] npu_rdata;
   logic          npu_done;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rdata;

   // master: the arbiter, which owns the SRAM port and answers both requesters
   modport master (
      input  cpu_rd, cpu_wr, cpu_addr, cpu_wd,
      output cpu_haz, cpu_rvalid, cpu_rdata,
      input  npu_req, npu_we, npu_addr, npu_wd, npu_burst_len,
      output npu_ack, npu_rvalid, npu_rdata, npu_done,
      output mem_en, mem_we, mem_addr, mem_wd,
      input  mem_rdata
   );

   modport slave (
      output cpu_rd, cpu_wr, cpu_addr, cpu_wd,
      input  cpu_haz, cpu_rvalid, cpu_rdata,
      output npu_req, npu_we, npu_addr, npu_wd, npu_burst_len,
      input  npu_ack, npu_rvalid, npu_rdata, npu_done,
      input  mem_en, mem_we, mem_addr, mem_wd,
      output mem_rdata
   );
endinterface

// File: rtl/npu_mem_arbiter.sv
// rtl/npu_mem_arbiter.sv - single-port data SRAM arbiter between CPU MEM stage and NPU burst engine
module npu_mem_arbiter #(
   parameter int DW           = 32,
   parameter int AW           = 32,
   parameter int MAX_NPU_RUN  = 8,
   parameter int NPU_WAIT_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   npu_mem_arbiter_if.master bus
);
   localparam int WAIT_W = $clog2(NPU_WAIT_MAX + 1);
   localparam int RUN_W  = $clog2(MAX_NPU_RUN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [WAIT_W-1:0]  npu_wait, npu_wait_nxt;
   logic [RUN_W-1:0]   run_cnt, run_cnt_nxt;
   logic [7:0]         beats_left, beats_left_nxt;
   logic [7:0]         first_left;

   logic               cpu_req;
   logic               cpu_grant;
   logic               npu_grant;
   logic               wait_hit;
   logic               run_hit;

   logic               rd_pend;
   logic               rd_owner;
   logic [DW-1:0]      cpu_rdata_q;
   logic [DW-1:0]      npu_rdata_q;

   assign cpu_req    = bus.cpu_rd | bus.cpu_wr;
   assign wait_hit   = (npu_wait == WAIT_W'(NPU_WAIT_MAX));
   assign run_hit    = (run_cnt == RUN_W'(MAX_NPU_RUN));
   assign first_left = (bus.npu_burst_len == 8'd0) ? 8'd0 : bus.npu_burst_len - 8'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         npu_wait    <= '0;
         run_cnt     <= '0;
         beats_left  <= '0;
         rd_pend     <= 1'b0;
         rd_owner    <= 1'b0;
         cpu_rdata_q <= '0;
         npu_rdata_q <= '0;
      end else begin
         state      <= state_nxt;
         npu_wait   <= npu_wait_nxt;
         run_cnt    <= run_cnt_nxt;
         beats_left <= beats_left_nxt;
         rd_pend    <= bus.mem_en & ~bus.mem_we;
         rd_owner   <= npu_grant;
         if (bus.cpu_rvalid) begin
            cpu_rdata_q <= bus.mem_rdata;
         end
         if (bus.npu_rvalid) begin
            npu_rdata_q <= bus.mem_rdata;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      npu_wait_nxt   = npu_wait;
      run_cnt_nxt    = run_cnt;
      beats_left_nxt = beats_left;
      case (state)
         S_IDLE: begin
            if (npu_grant) begin
               npu_wait_nxt   = '0;
               beats_left_nxt = first_left;
               run_cnt_nxt    = RUN_W'(1);
               state_nxt      = (first_left == 8'd0) ? S_DONE : S_RUN;
            end else if (bus.npu_req && !wait_hit) begin
               npu_wait_nxt = npu_wait + WAIT_W'(1);
            end
         end
         S_RUN: begin
            if (npu_grant) begin
               beats_left_nxt = beats_left - 8'd1;
               if (!run_hit) begin
                  run_cnt_nxt = run_cnt + RUN_W'(1);
               end
               if (beats_left == 8'd1) begin
                  state_nxt = S_DONE;
               end
            end else begin
               // Either the CPU took its forced slot or the NPU paused; both restart the run window.
               run_cnt_nxt = '0;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      cpu_grant = 1'b0;
      npu_grant = 1'b0;
      // Grants are gated by reset so nothing reaches the SRAM while the core is held.
      if (rst) begin
         case (state)
            S_IDLE: begin
               npu_grant = bus.npu_req & (~cpu_req | wait_hit);
               cpu_grant = cpu_req & ~npu_grant;
            end
            S_RUN: begin
               npu_grant = bus.npu_req & ~(cpu_req & run_hit);
               cpu_grant = cpu_req & ~npu_grant;
            end
            S_DONE: begin
               cpu_grant = cpu_req;
            end
            default: begin
               cpu_grant = 1'b0;
            end
         endcase
      end

      bus.cpu_haz  = rst & cpu_req & ~cpu_grant;
      bus.npu_ack  = npu_grant;
      bus.npu_done = (state == S_DONE);

      bus.mem_en = cpu_grant | npu_grant;
      if (cpu_grant) begin
         bus.mem_we   = bus.cpu_wr;
         bus.mem_addr = bus.cpu_addr;
         bus.mem_wd   = bus.cpu_wd;
      end else if (npu_grant) begin
         bus.mem_we   = bus.npu_we;
         bus.mem_addr = bus.npu_addr;
         bus.mem_wd   = bus.npu_wd;
      end else begin
         bus.mem_we   = 1'b0;
         bus.mem_addr = {AW{1'b0}};
         bus.mem_wd   = {DW{1'b0}};
      end

      bus.cpu_rvalid = rd_pend & ~rd_owner;
      bus.npu_rvalid = rd_pend & rd_owner;
      bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : cpu_rdata_q;
      bus.npu_rdata  = bus.npu_rvalid ? bus.mem_rdata : npu_rdata_q;
   end

   a_single_owner: assert property (@(posedge clk) disable iff (!rst) !(cpu_grant && npu_grant));
   a_ack_needs_req: assert property (@(posedge clk) disable iff (!rst) npu_grant |-> bus.npu_req);

endmodule

// File: doc/npu_mem_arbiter.md
Name: npu_mem_arbiter

Overview:
- Single-port data-memory arbiter shared by the CPU MEM stage and the NPU matrix engine.
- Issues at most one memory access per cycle and stalls the CPU through cpu_haz when it loses arbitration.
- Serves NPU bursts with a per-beat handshake, bounding starvation in both directions.
- Sits between the core's memory-port outputs and the synchronous data SRAM (1-cycle read latency).

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- MAX_NPU_RUN, 8, consecutive NPU beats allowed while a CPU request is pending before the CPU is forced a slot (≥1).
- NPU_WAIT_MAX, 4, consecutive cycles an NPU request may lose to the CPU in IDLE before the NPU wins (≥1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- cpu_rd  in  1  CPU load request
- cpu_wr  in  1  CPU store request (cpu_rd and cpu_wr are never both 1)
- cpu_addr  in  AW  CPU address
- cpu_wd  in  DW  CPU store data
- cpu_haz  out  1  CPU stall: request present but not served this cycle
- cpu_rvalid  out  1  pulse: cpu_rdata valid
- cpu_rdata  out  DW  CPU load data
- npu_req  in  1  NPU beat valid
- npu_we  in  1  NPU beat is a write
- npu_addr  in  AW  NPU beat address
- npu_wd  in  DW  NPU write data
- npu_burst_len  in  8  beats in burst, sampled on first beat; 0 treated as 1
- npu_ack  out  1  NPU beat accepted this cycle
- npu_rvalid  out  1  pulse: npu_rdata valid
- npu_rdata  out  DW  NPU read data
- npu_done  out  1  1-cycle pulse after final burst beat accepted
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM address
- mem_wd  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid the cycle after a read access

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; counters cleared. cpu_haz, cpu_rvalid, npu_ack, npu_rvalid, npu_done, mem_en and mem_we are all 0. cpu_rdata, npu_rdata, mem_addr and mem_wd are 0.
- Reset mid-burst: the burst is dropped, no npu_done is issued, and any read return in flight is discarded.
- Grant and memory-port signals are combinational from registered state and current requests. Served requester drives mem_en/mem_we/mem_addr/mem_wd the same cycle.
- cpu_req = cpu_rd | cpu_wr. cpu_haz = cpu_req & ~cpu_grant.
- npu_ack = npu_grant (requires npu_req).
- IDLE state:
  - cpu_req with npu_wait < NPU_WAIT_MAX: CPU served.
  - npu_req and not cpu_req: NPU served, npu_ack=1.
  - npu_req and cpu_req with npu_wait = NPU_WAIT_MAX: NPU served, npu_ack=1.
  - npu_wait increments each cycle npu_req loses, and clears on NPU grant.
  - On the first NPU grant: beats_left ← max(npu_burst_len,1)−1 and run_cnt ← 1. If beats_left becomes 0, go to DONE; otherwise go to NPU_RUN.
- NPU_RUN state:
  - npu_req served unless cpu_req and run_cnt = MAX_NPU_RUN. In that case the CPU is served, npu_ack=0 and run_cnt ← 0.
  - Each NPU grant decrements beats_left and increments run_cnt (saturating). Transition to DONE on the grant that makes beats_left=0.
  - npu_req=0 mid-burst: no NPU access. The CPU is served if it requests, and run_cnt is cleared. The burst stays open.
- DONE state: npu_done=1 for one cycle. The CPU is served if requesting; NPU is not served. Next state is IDLE.
- Read return:
  - A 1-bit owner register and a valid register capture each read grant.
  - Next cycle: cpu_rvalid or npu_rvalid = 1, and the matching rdata = mem_rdata.
  - The non-owner's rdata holds its last value.
- Writes produce no return pulse.
- A CPU and NPU access never occur in the same cycle. Every accepted beat maps to exactly one mem_en cycle.

Test Plan:
- Reset with cpu_rd=1 held → cpu_haz=0 only after rst releases; all outputs 0 during reset. First cycle after release: mem_en=1, mem_addr=cpu_addr, and cpu_rvalid=1 the following cycle with cpu_rdata=mem_rdata.
- IDLE, npu_req=1, npu_we=1, npu_burst_len=3, no CPU → npu_ack high 3 consecutive cycles, 3 SRAM writes at the supplied addresses, npu_done one cycle after the third beat, then IDLE.
- npu_burst_len=20, MAX_NPU_RUN=8, cpu_rd held from burst start → cpu_haz=1 for 8 cycles, CPU served on cycle 9 (npu_ack=0), NPU resumes. 20 NPU beats complete.
- CPU requesting every cycle in IDLE, npu_req=1 with NPU_WAIT_MAX=4 → CPU served 4 cycles, NPU served on cycle 5 (cpu_haz=1 that cycle).
- NPU read burst len=4 with npu_req dropped for 2 cycles after beat 2 while cpu_wr=1 → CPU store served in the gap with cpu_haz=0. Beats 3 and 4 are accepted after npu_req returns; 4 npu_rvalid pulses, each one cycle after its beat.
- Assert rst=0 mid-burst (beat 2 of 5) → immediate IDLE, no npu_done, no npu_rvalid for the in-flight read.
